// File: rtl/fwd_hazard_unit_if.sv
// rtl/fwd_hazard_unit_if.sv - decode/pipeline side bundle for the forwarding and hazard unit
interface fwd_hazard_unit_if #(
   parameter int ADDR_W  = 4,
   parameter int NUM_SRC = 3,
   parameter int CNT_W   = 16
);
   logic                        fwd_en;
   logic [NUM_SRC*ADDR_W-1:0]   src_addr;
   logic [NUM_SRC-1:0]          src_valid;
   logic [ADDR_W-1:0]           exe_dest;
   logic                        exe_wb_en;
   logic                        exe_mem_read;
   logic [ADDR_W-1:0]           mem_dest;
   logic                        mem_wb_en;
   logic [ADDR_W-1:0]           wb_dest;
   logic                        wb_wb_en;
   logic                        mul_start;
   logic [2*NUM_SRC-1:0]        sel_src;
   logic                        stall;
   logic                        mul_busy;
   logic [CNT_W-1:0]            stall_cnt;

   modport master (
      output fwd_en, src_addr, src_valid, exe_dest, exe_wb_en, exe_mem_read,
             mem_dest, mem_wb_en, wb_dest, wb_wb_en, mul_start,
      input  sel_src, stall, mul_busy, stall_cnt
   );

   modport slave (
      input  fwd_en, src_addr, src_valid, exe_dest, exe_wb_en, exe_mem_read,
             mem_dest, mem_wb_en, wb_dest, wb_wb_en, mul_start,
      output sel_src, stall, mul_busy, stall_cnt
   );
endinterface

// File: rtl/fwd_hazard_unit.sv
// rtl/fwd_hazard_unit.sv - operand forwarding selects, load-use/RAW stall, multi-cycle busy tracker
module fwd_hazard_unit #(
   parameter int ADDR_W  = 4,
   parameter int NUM_SRC = 3,
   parameter int MUL_LAT = 3,
   parameter int CNT_W   = 16
) (
   input  logic               clk,
   input  logic               rst,
   fwd_hazard_unit_if.slave   bus
);
   localparam int   CTR_W = $clog2(MUL_LAT) + 1;
   localparam logic MULTI = (MUL_LAT > 1);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t             state_q, state_d;
   logic [CTR_W-1:0]   ctr_q, ctr_d;
   logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

   logic [NUM_SRC-1:0]   m_exe, m_mem, m_wb;
   logic [2*NUM_SRC-1:0] sel;
   logic                 hazard;
   logic                 stall;
   logic                 mul_busy;

   assign mul_busy = (state_q == BUSY);

   always_comb begin
      m_exe  = '0;
      m_mem  = '0;
      m_wb   = '0;
      sel    = '0;
      hazard = 1'b0;
      for (int i = 0; i < NUM_SRC; i++) begin
         m_exe[i] = bus.src_valid[i] && (bus.src_addr[i*ADDR_W +: ADDR_W] == bus.exe_dest) && bus.exe_wb_en;
         m_mem[i] = bus.src_valid[i] && (bus.src_addr[i*ADDR_W +: ADDR_W] == bus.mem_dest) && bus.mem_wb_en;
         m_wb[i]  = bus.src_valid[i] && (bus.src_addr[i*ADDR_W +: ADDR_W] == bus.wb_dest)  && bus.wb_wb_en;
         // MEM holds the younger result, so it wins over WB
         if (bus.fwd_en) begin
            if (m_mem[i])
               sel[2*i +: 2] = 2'd1;
            else if (m_wb[i])
               sel[2*i +: 2] = 2'd2;
            if (m_exe[i] && bus.exe_mem_read)
               hazard = 1'b1;
         end else if (m_exe[i] || m_mem[i] || m_wb[i]) begin
            hazard = 1'b1;
         end
      end
   end

   assign stall = hazard || mul_busy;

   always_comb begin
      state_d     = state_q;
      ctr_d       = ctr_q;
      stall_cnt_d = stall_cnt_q;
      case (state_q)
         IDLE: begin
            if (bus.mul_start && !stall && MULTI) begin
               ctr_d   = CTR_W'(MUL_LAT - 1);
               state_d = BUSY;
            end
         end
         BUSY: begin
            ctr_d = ctr_q - CTR_W'(1);
            if (ctr_q <= CTR_W'(1))
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (stall && (stall_cnt_q != {CNT_W{1'b1}}))
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         ctr_q       <= '0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         ctr_q       <= ctr_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign bus.sel_src   = sel;
   assign bus.stall     = stall;
   assign bus.mul_busy  = mul_busy;
   assign bus.stall_cnt = stall_cnt_q;
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb/tb_fwd_hazard_unit.sv - directed self-checking bench for fwd_hazard_unit
module tb_fwd_hazard_unit;
   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;
   int   exp_cnt;

   fwd_hazard_unit_if #(.ADDR_W(4), .NUM_SRC(3), .CNT_W(16)) bus ();
   fwd_hazard_unit_if #(.ADDR_W(4), .NUM_SRC(3), .CNT_W(4))  bus_s ();

   fwd_hazard_unit #(.ADDR_W(4), .NUM_SRC(3), .MUL_LAT(3), .CNT_W(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   fwd_hazard_unit #(.ADDR_W(4), .NUM_SRC(3), .MUL_LAT(1), .CNT_W(4)) dut_s (
      .clk (clk),
      .rst (rst),
      .bus (bus_s)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      bus.fwd_en = 1'b1; bus.src_addr = '0; bus.src_valid = '0;
      bus.exe_dest = '0; bus.exe_wb_en = 1'b0; bus.exe_mem_read = 1'b0;
      bus.mem_dest = '0; bus.mem_wb_en = 1'b0; bus.wb_dest = '0; bus.wb_wb_en = 1'b0;
      bus.mul_start = 1'b0;
      bus_s.fwd_en = 1'b1; bus_s.src_addr = '0; bus_s.src_valid = '0;
      bus_s.exe_dest = '0; bus_s.exe_wb_en = 1'b0; bus_s.exe_mem_read = 1'b0;
      bus_s.mem_dest = '0; bus_s.mem_wb_en = 1'b0; bus_s.wb_dest = '0; bus_s.wb_wb_en = 1'b0;
      bus_s.mul_start = 1'b0;
   endtask

   task automatic test_reset();
      clear_inputs();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      #1;
      exp_cnt = 0;
      n_checks++; if (bus.stall_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_stall_cnt got %0d want 0", bus.stall_cnt); end
      n_checks++; if (bus.mul_busy !== 1'b0) begin n_fail++; $display("FAIL reset_mul_busy got %b want 0", bus.mul_busy); end
      n_checks++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b want 0", bus.stall); end
      n_checks++; if (bus.sel_src !== 6'd0) begin n_fail++; $display("FAIL reset_sel_src got %b want 000000", bus.sel_src); end
      n_checks++; if (bus_s.stall_cnt !== 4'd0) begin n_fail++; $display("FAIL reset_sat_cnt got %0d want 0", bus_s.stall_cnt); end
   endtask

   task automatic test_forward_priority();
      tick();
      clear_inputs();
      bus.src_addr = {4'd0, 4'd0, 4'd4}; bus.src_valid = 3'b001;
      bus.mem_dest = 4'd4; bus.mem_wb_en = 1'b1; bus.wb_dest = 4'd4; bus.wb_wb_en = 1'b1;
      #1;
      n_checks++; if (bus.sel_src !== 6'b000001) begin n_fail++; $display("FAIL fwd_mem_priority got %b want 000001", bus.sel_src); end
      n_checks++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL fwd_no_stall got %b want 0", bus.stall); end
      bus.mem_wb_en = 1'b0;
      #1;
      n_checks++; if (bus.sel_src[1:0] !== 2'd2) begin n_fail++; $display("FAIL fwd_wb got %0d want 2", bus.sel_src[1:0]); end
      bus.wb_wb_en = 1'b0;
      #1;
      n_checks++; if (bus.sel_src[1:0] !== 2'd0) begin n_fail++; $display("FAIL fwd_none got %0d want 0", bus.sel_src[1:0]); end
      bus.mem_wb_en = 1'b1; bus.wb_wb_en = 1'b1; bus.src_valid = 3'b000;
      #1;
      n_checks++; if (bus.sel_src !== 6'd0) begin n_fail++; $display("FAIL fwd_invalid_src got %b want 000000", bus.sel_src); end
      bus.src_addr = {4'd4, 4'd9, 4'd0}; bus.src_valid = 3'b100; bus.wb_dest = 4'd9;
      #1;
      n_checks++; if (bus.sel_src !== 6'b010000) begin n_fail++; $display("FAIL fwd_op2_mem got %b want 010000", bus.sel_src); end
      bus.src_valid = 3'b110;
      #1;
      n_checks++; if (bus.sel_src !== 6'b011000) begin n_fail++; $display("FAIL fwd_op1_op2 got %b want 011000", bus.sel_src); end
   endtask

   task automatic test_load_use();
      tick();
      clear_inputs();
      bus.exe_dest = 4'd7; bus.exe_wb_en = 1'b1; bus.exe_mem_read = 1'b1;
      bus.src_addr = {4'd7, 4'd0, 4'd0}; bus.src_valid = 3'b100;
      #1;
      n_checks++; if (bus.stall !== 1'b1) begin n_fail++; $display("FAIL load_use_stall got %b want 1", bus.stall); end
      n_checks++; if (bus.sel_src !== 6'd0) begin n_fail++; $display("FAIL load_use_sel got %b want 000000", bus.sel_src); end
      for (int i = 0; i < 3; i++) begin
         tick();
         exp_cnt++;
         n_checks++; if (bus.stall_cnt !== 16'(exp_cnt)) begin n_fail++; $display("FAIL load_use_cnt got %0d want %0d", bus.stall_cnt, exp_cnt); end
      end
      bus.exe_mem_read = 1'b0;
      #1;
      n_checks++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL no_load_no_stall got %b want 0", bus.stall); end
      tick();
      n_checks++; if (bus.stall_cnt !== 16'(exp_cnt)) begin n_fail++; $display("FAIL cnt_hold got %0d want %0d", bus.stall_cnt, exp_cnt); end
   endtask

   task automatic test_stall_only();
      tick();
      clear_inputs();
      bus.fwd_en = 1'b0; bus.wb_dest = 4'd3; bus.wb_wb_en = 1'b1;
      bus.src_addr = {4'd0, 4'd3, 4'd0}; bus.src_valid = 3'b010;
      #1;
      n_checks++; if (bus.stall !== 1'b1) begin n_fail++; $display("FAIL stall_only_stall got %b want 1", bus.stall); end
      n_checks++; if (bus.sel_src !== 6'd0) begin n_fail++; $display("FAIL stall_only_sel got %b want 000000", bus.sel_src); end
      bus.fwd_en = 1'b1;
      #1;
      n_checks++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL fwd_mode_stall got %b want 0", bus.stall); end
      n_checks++; if (bus.sel_src !== 6'b001000) begin n_fail++; $display("FAIL fwd_mode_sel got %b want 001000", bus.sel_src); end
      bus.wb_wb_en = 1'b0; bus.fwd_en = 1'b0;
      bus.exe_dest = 4'd3; bus.exe_wb_en = 1'b1;
      #1;
      n_checks++; if (bus.stall !== 1'b1) begin n_fail++; $display("FAIL stall_only_exe got %b want 1", bus.stall); end
      clear_inputs();
   endtask

   task automatic test_multi_cycle();
      tick();
      clear_inputs();
      bus.mul_start = 1'b1;
      #1;
      n_checks++; if (bus.mul_busy !== 1'b0) begin n_fail++; $display("FAIL mul_pre_busy got %b want 0", bus.mul_busy); end
      tick();
      bus.mul_start = 1'b0;
      n_checks++; if (bus.stall !== 1'b1) begin n_fail++; $display("FAIL mul_busy1 got %b want 1", bus.stall); end
      tick();
      exp_cnt++;
      n_checks++; if (bus.mul_busy !== 1'b1) begin n_fail++; $display("FAIL mul_busy2 got %b want 1", bus.mul_busy); end
      tick();
      exp_cnt++;
      n_checks++; if (bus.mul_busy !== 1'b0) begin n_fail++; $display("FAIL mul_done got %b want 0", bus.mul_busy); end
      n_checks++; if (bus.stall_cnt !== 16'(exp_cnt)) begin n_fail++; $display("FAIL mul_cnt got %0d want %0d", bus.stall_cnt, exp_cnt); end
      tick();
      n_checks++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL mul_idle got %b want 0", bus.stall); end

      bus.mul_start = 1'b1;
      tick();
      tick();
      exp_cnt++;
      tick();
      exp_cnt++;
      n_checks++; if (bus.mul_busy !== 1'b0) begin n_fail++; $display("FAIL mul_held_gap got %b want 0", bus.mul_busy); end
      tick();
      n_checks++; if (bus.mul_busy !== 1'b1) begin n_fail++; $display("FAIL mul_reaccept got %b want 1", bus.mul_busy); end
      bus.mul_start = 1'b0;
      tick();
      exp_cnt++;
      tick();
      exp_cnt++;
      n_checks++; if (bus.mul_busy !== 1'b0) begin n_fail++; $display("FAIL mul_held_done got %b want 0", bus.mul_busy); end

      bus.exe_dest = 4'd2; bus.exe_wb_en = 1'b1; bus.exe_mem_read = 1'b1;
      bus.src_addr = {4'd0, 4'd0, 4'd2}; bus.src_valid = 3'b001; bus.mul_start = 1'b1;
      tick();
      exp_cnt++;
      n_checks++; if (bus.mul_busy !== 1'b0) begin n_fail++; $display("FAIL mul_blocked_by_hazard got %b want 0", bus.mul_busy); end
      clear_inputs();
      #1;
      n_checks++; if (bus.stall_cnt !== 16'(exp_cnt)) begin n_fail++; $display("FAIL mul_total_cnt got %0d want %0d", bus.stall_cnt, exp_cnt); end
   endtask

   task automatic test_reset_mid_op();
      tick();
      clear_inputs();
      bus.mul_start = 1'b1;
      tick();
      bus.mul_start = 1'b0;
      n_checks++; if (bus.mul_busy !== 1'b1) begin n_fail++; $display("FAIL rst_mid_busy got %b want 1", bus.mul_busy); end
      rst = 1'b1;
      #1;
      n_checks++; if (bus.stall !== 1'b1) begin n_fail++; $display("FAIL rst_mid_stall got %b want 1", bus.stall); end
      tick();
      rst = 1'b0;
      exp_cnt = 0;
      n_checks++; if (bus.mul_busy !== 1'b0) begin n_fail++; $display("FAIL rst_abort_busy got %b want 0", bus.mul_busy); end
      n_checks++; if (bus.stall_cnt !== 16'd0) begin n_fail++; $display("FAIL rst_abort_cnt got %0d want 0", bus.stall_cnt); end
      tick();
      n_checks++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL rst_after_idle got %b want 0", bus.stall); end
   endtask

   task automatic test_saturation();
      int want;
      tick();
      clear_inputs();
      bus_s.mul_start = 1'b1;
      tick();
      n_checks++; if (bus_s.mul_busy !== 1'b0) begin n_fail++; $display("FAIL lat1_never_busy got %b want 0", bus_s.mul_busy); end
      n_checks++; if (bus_s.stall_cnt !== 4'd0) begin n_fail++; $display("FAIL lat1_no_cnt got %0d want 0", bus_s.stall_cnt); end
      bus_s.mul_start = 1'b0;
      bus_s.exe_dest = 4'd15; bus_s.exe_wb_en = 1'b1; bus_s.exe_mem_read = 1'b1;
      bus_s.src_addr = {4'd0, 4'd15, 4'd0}; bus_s.src_valid = 3'b010;
      for (int i = 1; i <= 20; i++) begin
         tick();
         want = (i > 15) ? 15 : i;
         n_checks++; if (bus_s.stall_cnt !== 4'(want)) begin n_fail++; $display("FAIL sat_cnt cycle %0d got %0d want %0d", i, bus_s.stall_cnt, want); end
      end
      clear_inputs();
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      exp_cnt  = 0;
      rst      = 1'b1;
      clear_inputs();
      test_reset();
      test_forward_priority();
      test_load_use();
      test_stall_only();
      test_multi_cycle();
      test_reset_mid_op();
      test_saturation();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
Parametrised forwarding and hazard controller for the pipelined ARM core, sitting between ID/EXE decode and the pipeline registers. It generalises operand forwarding to NUM_SRC source operands and detects load-use hazards. It adds a forwarding-disable mode that stalls on every RAW hazard, a multi-cycle-op busy tracker, and a saturating stall-cycle counter.

Parameters:
ADDR_W, 4, register address width
NUM_SRC, 3, number of source operands checked (Rn, Rm, Rs)
MUL_LAT, 3, cycles a multi-cycle op occupies EXE (>=1)
CNT_W, 16, width of stall statistics counter

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous active-high reset
fwd_en  in  1  1 = forwarding mode, 0 = stall-only mode
src_addr  in  NUM_SRC*ADDR_W  ID-stage source addresses, operand i at bits [i*ADDR_W +: ADDR_W]
src_valid  in  NUM_SRC  operand i actually read
exe_dest  in  ADDR_W  EXE-stage destination
exe_wb_en  in  1  EXE instruction writes back
exe_mem_read  in  1  EXE instruction is a load
mem_dest  in  ADDR_W  MEM-stage destination
mem_wb_en  in  1  MEM instruction writes back
wb_dest  in  ADDR_W  WB-stage destination
wb_wb_en  in  1  WB instruction writes back
mul_start  in  1  ID instruction is a multi-cycle op requesting issue
sel_src  out  2*NUM_SRC  forwarding select per operand, operand i at bits [2*i +: 2]
stall  out  1  freeze PC/IF/ID, bubble into EXE
mul_busy  out  1  multi-cycle op in progress
stall_cnt  out  CNT_W  saturating count of stalled cycles

Behaviour:
- Match m_X(i) = src_valid[i] & (src_addr_i == X_dest) & X_wb_en, for X in {exe, mem, wb}.
- sel_src (combinational): fwd_en=0 gives 0 for all operands. Otherwise m_mem gives 1, else m_wb gives 2, else 0. MEM has priority over WB. Code 3 is never driven.
- hazard (combinational):
  - fwd_en=1: any i with m_exe(i) & exe_mem_read (load-use).
  - fwd_en=0: any i with m_exe, m_mem or m_wb.
- stall = hazard | mul_busy (combinational).
- Multi-cycle FSM, states IDLE/BUSY, down-counter ctr of width clog2(MUL_LAT)+1:
  - IDLE: if mul_start & ~stall and MUL_LAT>1, load ctr = MUL_LAT-1 and go to BUSY. Otherwise remain in IDLE.
  - BUSY: decrement ctr each cycle. Return to IDLE when ctr reaches 0 (transition taken on the edge where ctr==1).
  - mul_busy = (state==BUSY), registered.
  - Result: an accepted op stalls exactly MUL_LAT-1 cycles starting the cycle after acceptance.
  - mul_start while stall=1 is not accepted; ID must hold it.
  - MUL_LAT=1: FSM never leaves IDLE and mul_busy stays 0.
- stall_cnt: increments on each rising edge where stall=1. Saturates at all-ones and does not wrap.
- Reset, sampled on rising edge: state=IDLE, ctr=0, mul_busy=0, stall_cnt=0.
  - Reset mid-BUSY aborts the op; mul_busy=0 the next cycle.
  - Combinational outputs track inputs during reset. stall reflects hazard only after the reset edge.
- Register 15 (PC) is treated like any other address; the pipeline never asserts wb_en for it.
- fwd_en may change any cycle; it takes effect combinationally.

Test Plan:
- Forward priority: fwd_en=1, src0=4, mem_dest=4/mem_wb_en=1, wb_dest=4/wb_wb_en=1 -> sel_src[1:0]=1. Drop mem_wb_en -> 2. Drop both -> 0. src_valid[0]=0 -> 0.
- Load-use: exe_dest=7, exe_wb_en=1, exe_mem_read=1, src2=7 -> stall=1, stall_cnt +1 per cycle. exe_mem_read=0 -> stall=0.
- Stall-only mode: fwd_en=0, wb_dest=3/wb_wb_en=1, src1=3 -> stall=1, sel_src=0. Same inputs with fwd_en=1 -> stall=0, sel_src[3:2]=2.
- Multi-cycle: MUL_LAT=3, mul_start pulsed one cycle, no hazards -> mul_busy/stall high exactly 2 cycles, then 0. mul_start held during busy -> not re-accepted until stall=0.
- Reset mid-op: rst asserted on first BUSY cycle -> next cycle mul_busy=0, stall_cnt=0, state IDLE.
- Saturation: CNT_W=4, hold hazard 20 cycles -> stall_cnt reaches 15 and stays 15.
